// File: rtl/fu_result_buffer_pkg.sv
// Shared defaults and payload type for the functional-unit result buffers
// that sit between the ALU/branch units and the CDB arbiter.
package fu_result_buffer_pkg;

  localparam int DEF_WIDTH   = 31;
  localparam int DEF_ROB     = 2;
  localparam int DEF_CONTROL = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PTR     = 1;

  typedef struct packed {
    logic [DEF_WIDTH:0]   result;
    logic [DEF_ROB:0]     robEntry;
    logic [DEF_WIDTH:0]   targetAddress;
    logic [DEF_CONTROL:0] pcControl;
  } cdb_payload_t;

  // Packed width of one payload entry for a given set of MSB indices.
  function automatic int payload_bits(input int width, input int rob, input int control);
    return 2 * (width + 1) + (rob + 1) + (control + 1);
  endfunction

endpackage

// File: rtl/fu_result_buffer_storage.sv
// DEPTH-entry payload register file: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fu_result_buffer_storage #(
  parameter int DW    = 71,
  parameter int DEPTH = 4,
  parameter int PTR   = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PTR:0]  waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PTR:0]  raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fu_result_buffer.sv
// Result FIFO between one functional unit and the CDB arbiter. The oldest
// entry is presented as a CDB request and popped when the arbiter grants.
module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ROB     = DEF_ROB,
  parameter int CONTROL = DEF_CONTROL,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PTR     = DEF_PTR
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             clear,
  input  logic             validCommit,
  input  logic             inValid,
  input  logic [WIDTH:0]   inResult,
  input  logic [ROB:0]     inRob,
  input  logic [WIDTH:0]   inTarget,
  input  logic [CONTROL:0] inControl,
  output logic             inReady,
  output logic             request,
  output logic [WIDTH:0]   outResult,
  output logic [ROB:0]     outRob,
  output logic [WIDTH:0]   outTarget,
  output logic [CONTROL:0] outControl,
  input  logic             available,
  output logic [PTR+1:0]   count
);

  typedef struct packed {
    logic [WIDTH:0]   result;
    logic [ROB:0]     robEntry;
    logic [WIDTH:0]   targetAddress;
    logic [CONTROL:0] pcControl;
  } payload_t;

  localparam int             PW         = payload_bits(WIDTH, ROB, CONTROL);
  localparam logic [PTR+1:0] FULL_COUNT = (PTR + 2)'(DEPTH);

  payload_t       wrData;
  payload_t       rdData;
  logic [PTR:0]   wrPtr;
  logic [PTR:0]   rdPtr;
  logic [PTR+1:0] cnt;
  logic           push;
  logic           pop;
  logic           flush;

  // Full/empty come from the registered count only, so inReady never
  // depends combinationally on the arbiter's available.
  assign inReady = (cnt != FULL_COUNT);
  assign request = (cnt != '0);
  assign count   = cnt;

  assign push  = inValid & inReady;
  assign pop   = request & available;
  assign flush = clear & validCommit;

  always_comb begin
    wrData               = '0;
    wrData.result        = inResult;
    wrData.robEntry      = inRob;
    wrData.targetAddress = inTarget;
    wrData.pcControl     = inControl;
  end

  assign outResult  = rdData.result;
  assign outRob     = rdData.robEntry;
  assign outTarget  = rdData.targetAddress;
  assign outControl = rdData.pcControl;

  fu_result_buffer_storage #(
    .DW    (PW),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_storage (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wrPtr),
    .wdata (wrData),
    .raddr (rdPtr),
    .rdata (rdData)
  );

  // Flush outranks push and pop; a grant landing in the flush cycle is lost
  // with the squashed entry.
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!globalReset) !(inValid && !inReady));

  a_count_bounded : assert property (
    @(posedge clk) disable iff (!globalReset) cnt <= FULL_COUNT);

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed bench for fu_result_buffer: reset, single pass, back-pressure,
// pointer wrap with concurrent push/pop, flush, and async reset mid-stream.
module tb_fu_result_buffer;

  logic        clk;
  logic        globalReset;
  logic        clear;
  logic        validCommit;
  logic        inValid;
  logic [31:0] inResult;
  logic [2:0]  inRob;
  logic [31:0] inTarget;
  logic [4:0]  inControl;
  logic        inReady;
  logic        request;
  logic [31:0] outResult;
  logic [2:0]  outRob;
  logic [31:0] outTarget;
  logic [4:0]  outControl;
  logic        available;
  logic [2:0]  count;

  int unsigned checks;
  int unsigned failures;

  fu_result_buffer #(
    .WIDTH   (31),
    .ROB     (2),
    .CONTROL (4),
    .DEPTH   (4),
    .PTR     (1)
  ) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .clear       (clear),
    .validCommit (validCommit),
    .inValid     (inValid),
    .inResult    (inResult),
    .inRob       (inRob),
    .inTarget    (inTarget),
    .inControl   (inControl),
    .inReady     (inReady),
    .request     (request),
    .outResult   (outResult),
    .outRob      (outRob),
    .outTarget   (outTarget),
    .outControl  (outControl),
    .available   (available),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [2:0] rob, input logic [31:0] res);
    inValid   = 1'b1;
    inRob     = rob;
    inResult  = res;
    inTarget  = res ^ 32'hFFFF_0000;
    inControl = {2'b00, rob};
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    globalReset = 1'b0;
    clear       = 1'b0;
    validCommit = 1'b0;
    inValid     = 1'b0;
    inResult    = '0;
    inRob       = '0;
    inTarget    = '0;
    inControl   = '0;
    available   = 1'b0;

    // Reset then idle
    tick();
    tick();
    check("rst_request", {31'd0, request}, 32'd0);
    check("rst_inReady", {31'd0, inReady}, 32'd1);
    check("rst_count", {29'd0, count}, 32'd0);
    #2 globalReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_request", {31'd0, request}, 32'd0);
    end

    // Single pass with arbiter always available
    available = 1'b1;
    drive_push(3'd3, 32'h0000_00AA);
    inTarget  = 32'h0000_4000;
    inControl = 5'h15;
    tick();
    inValid = 1'b0;
    check("single_request", {31'd0, request}, 32'd1);
    check("single_rob", {29'd0, outRob}, 32'd3);
    check("single_result", outResult, 32'h0000_00AA);
    check("single_target", outTarget, 32'h0000_4000);
    check("single_control", {27'd0, outControl}, 32'h15);
    check("single_count", {29'd0, count}, 32'd1);
    tick();
    check("single_drain_req", {31'd0, request}, 32'd0);
    check("single_drain_cnt", {29'd0, count}, 32'd0);

    // Back-pressure: fill to DEPTH, then drain in order
    available = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_push(3'(i), 32'h100 + 32'(i));
      tick();
    end
    inValid = 1'b0;
    check("bp_full_count", {29'd0, count}, 32'd4);
    check("bp_full_inReady", {31'd0, inReady}, 32'd0);
    available = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_head_rob", {29'd0, outRob}, 32'(i));
      check("bp_head_result", outResult, 32'h100 + 32'(i));
      tick();
      check("bp_count", {29'd0, count}, 32'(4 - i));
      check("bp_inReady", {31'd0, inReady}, 32'd1);
    end
    check("bp_empty_req", {31'd0, request}, 32'd0);

    // Push and pop every cycle across pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive_push(3'(k % 8), 32'hC000 + 32'(k));
      tick();
      check("wrap_count", {29'd0, count}, 32'd1);
      check("wrap_rob", {29'd0, outRob}, 32'(k % 8));
      check("wrap_result", outResult, 32'hC000 + 32'(k));
      check("wrap_target", outTarget, (32'hC000 + 32'(k)) ^ 32'hFFFF_0000);
    end
    inValid = 1'b0;
    tick();
    check("wrap_drain_cnt", {29'd0, count}, 32'd0);

    // Flush with same-cycle push
    available = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      drive_push(3'(i), 32'h500 + 32'(i));
      tick();
    end
    check("flush_pre_count", {29'd0, count}, 32'd3);
    drive_push(3'd2, 32'hDEAD);
    clear       = 1'b1;
    validCommit = 1'b1;
    available   = 1'b1;
    tick();
    inValid     = 1'b0;
    clear       = 1'b0;
    validCommit = 1'b0;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_request", {31'd0, request}, 32'd0);
    tick();
    check("flush_push_gone", {29'd0, count}, 32'd0);

    // clear without validCommit has no effect
    available = 1'b0;
    drive_push(3'd6, 32'h0600);
    tick();
    drive_push(3'd1, 32'h0601);
    tick();
    inValid = 1'b0;
    clear   = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_only_count", {29'd0, count}, 32'd2);
    check("clear_only_head", {29'd0, outRob}, 32'd6);
    check("clear_only_result", outResult, 32'h0600);

    // Async reset between edges
    #3 globalReset = 1'b0;
    #1;
    check("async_count", {29'd0, count}, 32'd0);
    check("async_request", {31'd0, request}, 32'd0);
    check("async_inReady", {31'd0, inReady}, 32'd1);
    #1 globalReset = 1'b1;
    drive_push(3'd4, 32'h0777);
    tick();
    inValid = 1'b0;
    check("post_rst_count", {29'd0, count}, 32'd1);
    check("post_rst_rob", {29'd0, outRob}, 32'd4);
    check("post_rst_result", outResult, 32'h0777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fu_result_buffer.md
Name: fu_result_buffer

Overview:
- Small FIFO between one functional unit (ALU or branch unit) and the common-data-bus arbiter.
- Captures each completed result with its ROB entry, target address and PC-control bits.
- Presents the oldest entry as a CDB request and pops it when the arbiter grants.
- Frees the functional unit from stalling on a lost arbitration round; flushed on mispredict commit.

Parameters:
- WIDTH, 31: MSB index of result/target address (data is WIDTH+1 bits).
- ROB, 2: MSB index of ROB entry tag.
- CONTROL, 4: MSB index of PC-control field.
- DEPTH, 4: number of entries; power of two, at least 2.
- PTR, 1: MSB index of read/write pointers; equals log2(DEPTH)-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- globalReset  in  1  reset, asynchronous, active-low (0 = reset).
- clear  in  1  pipeline flush request.
- validCommit  in  1  commit valid; flush only when clear & validCommit.
- inValid  in  1  functional unit has a completed result this cycle.
- inResult  in  WIDTH+1  result value.
- inRob  in  ROB+1  ROB entry of the producing instruction.
- inTarget  in  WIDTH+1  branch target / fetch address (don't-care for ALU).
- inControl  in  CONTROL+1  PC-control bits (don't-care for ALU).
- inReady  out  1  buffer can accept a push this cycle.
- request  out  1  to arbiter ALURequest/branchRequest.
- outResult  out  WIDTH+1  head result.
- outRob  out  ROB+1  head ROB entry.
- outTarget  out  WIDTH+1  head target address.
- outControl  out  CONTROL+1  head PC-control bits.
- available  in  1  arbiter aluAvailable/branchAvailable.
- count  out  PTR+2  occupancy, 0..DEPTH.

Behaviour:
- Reset (globalReset=0, async): wrPtr=rdPtr=0, count=0, request=0, inReady=1; storage contents undefined; out* read storage and are don't-care while request=0.
- request = (count != 0), combinational from registered count; out* = storage[rdPtr] (registered storage, combinational read).
- push = inValid & inReady; pop = request & available. available=1 with request=1 means granted.
- inReady = (count != DEPTH). No same-cycle full bypass, so no combinational arbiter-to-FU path.
- Push writes storage[wrPtr] and advances wrPtr (mod DEPTH). Pop advances rdPtr (mod DEPTH).
- count updates: +1 on push only; -1 on pop only; unchanged on push+pop.
- Latency: a result pushed in cycle N is first requested in cycle N+1; the arbiter registers it onto the CDB at the end of that cycle if granted. With no bypass, minimum FU-to-CDB latency is 2 cycles.
- Empty with push: head becomes that entry next cycle; no bypass to request the same cycle.
- Full: inValid with inReady=0 is an FU protocol violation; the FU must hold. Assertion: inValid & !inReady never occurs.
- Simultaneous push and pop when not full: both take effect; FIFO order is preserved.
- Pointers wrap naturally via PTR+1-bit counters; full/empty are decided by count, not pointer equality.
- Flush (clear & validCommit, synchronous) has priority over push and pop:
  - wrPtr=rdPtr=0, count=0; request=0 next cycle.
  - A same-cycle push is discarded.
  - The arbiter drops its own validBroadcast that cycle, so a same-cycle grant is also lost; this is acceptable because the entry is squashed.
- clear without validCommit: no effect.
- Async reset mid-operation clears all state immediately; the first edge after release behaves as from empty.
- Order is strict FIFO; no reordering by ROB age.

Decomposition:
- Shared package (cpu_pkg): WIDTH/ROB/CONTROL defaults; typedef cdb_payload_t struct {result, robEntry, targetAddress, pcControl}. The storage array and in/out ports use this struct internally.
- Optional sub-module fu_result_storage: DEPTH x cdb_payload_t register file, one write port, one async read port. All pointer/count/flush control stays in fu_result_buffer.
- Two instances at top level: one for ALU, one for branch unit, feeding CDBArbiter request/data and taking its available outputs.

Test Plan:
- Reset then idle: hold globalReset=0 two cycles, release -> request=0, inReady=1, count=0; never asserts request.
- Single pass: push {result=0x0000_00AA, rob=3} with available=1 -> request=1 next cycle, outRob=3; then request=0, count=0 the cycle after.
- Back-pressure: hold available=0, push 4 entries rob=1,2,3,4 -> count=4, inReady=0; then available=1 -> pops rob 1,2,3,4 in order over 4 cycles, inReady=1 after first pop.
- Wrap and concurrency: push and pop every cycle for 10 cycles with rob=0..7 cycling -> count stays 1, outputs match input order delayed by 1 cycle across pointer wrap.
- Flush: 3 entries queued, assert clear=1, validCommit=1 with inValid=1 same cycle -> next cycle count=0, request=0; pushed entry absent. clear=1, validCommit=0 -> count unchanged.
- Async reset mid-stream: count=2, drop globalReset between clock edges -> count=0 and request=0 immediately, before the next edge.
